// File: rtl/filter_ram_addr_gen.sv
// Filter RAM read-address generator: walks a KxK window over C channels and
// replays the whole filter R times, flagging row, pass and job boundaries.
module filter_ram_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int K_W    = 3,
    parameter int CH_W   = 4,
    parameter int REP_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              CLEAR,
    input  logic              EN,
    input  logic [ADDR_W-1:0] CFG_BASE,
    input  logic [K_W-1:0]    CFG_K,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [ADDR_W-1:0] CFG_CH_STRIDE,
    input  logic [REP_W-1:0]  CFG_REP,
    output logic [ADDR_W-1:0] FILTER_RAM_ADDR,
    output logic              ADDR_VALID,
    output logic              ROW_LAST,
    output logic              PASS_LAST,
    output logic              DONE,
    output logic              BUSY
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_base, r_stride, r_row_base, r_ch_base, r_addr;
    logic [K_W-1:0]    r_k, r_col, r_row;
    logic [CH_W-1:0]   r_c, r_ch;
    logic [REP_W-1:0]  r_rep, r_pass;
    logic              r_valid, r_row_last, r_pass_last, r_done;

    logic [ADDR_W-1:0] w_base_nxt, w_stride_nxt, w_row_base_nxt, w_ch_base_nxt, w_addr_nxt;
    logic [K_W-1:0]    w_k_nxt, w_col_nxt, w_row_nxt;
    logic [CH_W-1:0]   w_c_nxt, w_ch_nxt;
    logic [REP_W-1:0]  w_rep_nxt, w_pass_nxt;
    logic              w_valid_nxt, w_row_last_nxt, w_pass_last_nxt, w_done_nxt;

    logic [K_W-1:0]    w_k_in;
    logic [CH_W-1:0]   w_c_in;
    logic [REP_W-1:0]  w_rep_in;
    logic              w_col_end, w_row_end, w_ch_end, w_rep_end;

    // Zero-sized configs collapse to one so every counter has at least one step.
    assign w_k_in   = (CFG_K   == {K_W{1'b0}})   ? K_ONE   : CFG_K;
    assign w_c_in   = (CFG_CH  == {CH_W{1'b0}})  ? CH_ONE  : CFG_CH;
    assign w_rep_in = (CFG_REP == {REP_W{1'b0}}) ? REP_ONE : CFG_REP;

    assign w_col_end = (r_col  == r_k   - K_ONE);
    assign w_row_end = (r_row  == r_k   - K_ONE);
    assign w_ch_end  = (r_ch   == r_c   - CH_ONE);
    assign w_rep_end = (r_pass == r_rep - REP_ONE);

    // Next-state and next-output decode for the IDLE/RUN walk.
    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_stride_nxt    = r_stride;
        w_k_nxt         = r_k;
        w_c_nxt         = r_c;
        w_rep_nxt       = r_rep;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_ch_nxt        = r_ch;
        w_pass_nxt      = r_pass;
        w_row_base_nxt  = r_row_base;
        w_ch_base_nxt   = r_ch_base;
        w_addr_nxt      = r_addr;
        w_done_nxt      = 1'b0;
        w_valid_nxt     = 1'b0;
        w_row_last_nxt  = 1'b0;
        w_pass_last_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt    = S_RUN;
                    w_base_nxt     = CFG_BASE;
                    w_stride_nxt   = CFG_CH_STRIDE;
                    w_k_nxt        = w_k_in;
                    w_c_nxt        = w_c_in;
                    w_rep_nxt      = w_rep_in;
                    w_col_nxt      = {K_W{1'b0}};
                    w_row_nxt      = {K_W{1'b0}};
                    w_ch_nxt       = {CH_W{1'b0}};
                    w_pass_nxt     = {REP_W{1'b0}};
                    w_row_base_nxt = CFG_BASE;
                    w_ch_base_nxt  = CFG_BASE;
                    w_addr_nxt     = CFG_BASE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (!EN) begin
                    w_state_nxt = S_RUN;
                end else if (!w_col_end) begin
                    w_col_nxt  = r_col + K_ONE;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end else if (!w_row_end) begin
                    w_col_nxt      = {K_W{1'b0}};
                    w_row_nxt      = r_row + K_ONE;
                    w_row_base_nxt = r_row_base + ADDR_W'(r_k);
                    w_addr_nxt     = r_row_base + ADDR_W'(r_k);
                end else if (!w_ch_end) begin
                    w_col_nxt      = {K_W{1'b0}};
                    w_row_nxt      = {K_W{1'b0}};
                    w_ch_nxt       = r_ch + CH_ONE;
                    w_ch_base_nxt  = r_ch_base + r_stride;
                    w_row_base_nxt = r_ch_base + r_stride;
                    w_addr_nxt     = r_ch_base + r_stride;
                end else if (!w_rep_end) begin
                    w_col_nxt      = {K_W{1'b0}};
                    w_row_nxt      = {K_W{1'b0}};
                    w_ch_nxt       = {CH_W{1'b0}};
                    w_pass_nxt     = r_pass + REP_ONE;
                    w_ch_base_nxt  = r_base;
                    w_row_base_nxt = r_base;
                    w_addr_nxt     = r_base;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Boundary flags describe the address that will be presented next.
        if (w_state_nxt == S_RUN) begin
            w_valid_nxt     = 1'b1;
            w_row_last_nxt  = (w_col_nxt == w_k_nxt - K_ONE);
            w_pass_last_nxt = (w_col_nxt == w_k_nxt - K_ONE) &&
                              (w_row_nxt == w_k_nxt - K_ONE) &&
                              (w_ch_nxt  == w_c_nxt - CH_ONE);
        end else begin
            w_valid_nxt     = 1'b0;
            w_row_last_nxt  = 1'b0;
            w_pass_last_nxt = 1'b0;
        end
    end

    // State register; reset and abort both land in IDLE.
    always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, outputs and config; abort keeps the latched config.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_base      <= {ADDR_W{1'b0}};
            r_stride    <= {ADDR_W{1'b0}};
            r_k         <= {K_W{1'b0}};
            r_c         <= {CH_W{1'b0}};
            r_rep       <= {REP_W{1'b0}};
            r_col       <= {K_W{1'b0}};
            r_row       <= {K_W{1'b0}};
            r_ch        <= {CH_W{1'b0}};
            r_pass      <= {REP_W{1'b0}};
            r_row_base  <= {ADDR_W{1'b0}};
            r_ch_base   <= {ADDR_W{1'b0}};
            r_addr      <= {ADDR_W{1'b0}};
            r_valid     <= 1'b0;
            r_row_last  <= 1'b0;
            r_pass_last <= 1'b0;
            r_done      <= 1'b0;
        end else if (CLEAR) begin
            r_col       <= {K_W{1'b0}};
            r_row       <= {K_W{1'b0}};
            r_ch        <= {CH_W{1'b0}};
            r_pass      <= {REP_W{1'b0}};
            r_row_base  <= {ADDR_W{1'b0}};
            r_ch_base   <= {ADDR_W{1'b0}};
            r_addr      <= {ADDR_W{1'b0}};
            r_valid     <= 1'b0;
            r_row_last  <= 1'b0;
            r_pass_last <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_base      <= w_base_nxt;
            r_stride    <= w_stride_nxt;
            r_k         <= w_k_nxt;
            r_c         <= w_c_nxt;
            r_rep       <= w_rep_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_ch        <= w_ch_nxt;
            r_pass      <= w_pass_nxt;
            r_row_base  <= w_row_base_nxt;
            r_ch_base   <= w_ch_base_nxt;
            r_addr      <= w_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_row_last  <= w_row_last_nxt;
            r_pass_last <= w_pass_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign FILTER_RAM_ADDR = r_addr;
    assign ADDR_VALID      = r_valid;
    assign ROW_LAST        = r_row_last;
    assign PASS_LAST       = r_pass_last;
    assign DONE            = r_done;
    assign BUSY            = (r_state == S_RUN);

endmodule
